// File: rtl/fp_addsub_seq.sv
// Sequential floating-point adder/subtractor (no denormals, truncation by default).
// Define FP_ROUND_NEAREST_EN to add a ROUND state with round-to-nearest-even.
module fp_addsub_seq #(
    parameter int EXP_W = 4,
    parameter int MAN_W = 7,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         sub,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] result,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         ovf,
    output logic         unf,
    output logic         zero
);
    // Working mantissa: hidden bit, fraction, guard/round/sticky; SW adds the carry bit.
    localparam int MW = MAN_W + 4;
    localparam int SW = MW + 1;
    localparam logic [W-2:0] MAG_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_ADD,
        S_NORM,
`ifdef FP_ROUND_NEAREST_EN
        S_ROUND,
`endif
        S_DONE
    } state_t;

    state_t             state_q;
    logic [W-1:0]       x_q, y_q;
    logic               sub_q;
    logic               sign_q;
    logic               eff_sub_q;
    logic [EXP_W-1:0]   exp_q;
    logic [MW-1:0]      big_q, small_q;
    logic [SW-1:0]      mant_q;
    logic [W-1:0]       result_q;
    logic               ovf_q, unf_q, zero_q;

    // Alignment datapath
    logic [EXP_W-1:0]       ex, ey, big_e, small_e, de;
    logic [W-2:0]           mag_x, mag_y;
    logic [MAN_W:0]         mx, my, big_m, small_m;
    logic [MW-1:0]          ext, shifted;
    logic                   sx, sy, x_ge;

    always_comb begin
        ex      = x_q[W-2:MAN_W];
        ey      = y_q[W-2:MAN_W];
        mag_x   = (ex == '0) ? '0 : x_q[W-2:0];
        mag_y   = (ey == '0) ? '0 : y_q[W-2:0];
        mx      = (ex == '0) ? '0 : {1'b1, x_q[MAN_W-1:0]};
        my      = (ey == '0) ? '0 : {1'b1, y_q[MAN_W-1:0]};
        sx      = x_q[W-1];
        sy      = y_q[W-1] ^ sub_q;
        x_ge    = (mag_x >= mag_y);
        big_e   = x_ge ? ex : ey;
        small_e = x_ge ? ey : ex;
        big_m   = x_ge ? mx : my;
        small_m = x_ge ? my : mx;
        de      = big_e - small_e;
        ext     = {small_m, 3'b000};
        if (int'(de) > MAN_W + 2) begin
            shifted = {{(MW-1){1'b0}}, |small_m};
        end else begin
            shifted    = ext >> de;
            shifted[0] = shifted[0] | (|(ext & ~({MW{1'b1}} << de)));
        end
    end

    logic [SW-1:0] sum_d;
    assign sum_d = eff_sub_q ? ({1'b0, big_q} - {1'b0, small_q})
                             : ({1'b0, big_q} + {1'b0, small_q});

    // One normalisation step
    logic [SW-1:0]    nm_d;
    logic [EXP_W-1:0] ne_d;
    logic             n_exit, n_ovf, n_unf, n_zero;

    always_comb begin
        nm_d   = mant_q;
        ne_d   = exp_q;
        n_exit = 1'b0;
        n_ovf  = 1'b0;
        n_unf  = 1'b0;
        n_zero = 1'b0;
        if (mant_q[SW-1]) begin
            n_exit = 1'b1;
            if (exp_q == '1) begin
                n_ovf = 1'b1;
            end else begin
                nm_d = {1'b0, mant_q[SW-1:2], |mant_q[1:0]};
                ne_d = exp_q + 1'b1;
            end
        end else if (mant_q[SW-2]) begin
            n_exit = 1'b1;
        end else if (mant_q == '0) begin
            n_exit = 1'b1;
            n_zero = 1'b1;
        end else if (exp_q <= EXP_W'(1)) begin
            n_exit = 1'b1;
            n_unf  = 1'b1;
        end else begin
            nm_d = mant_q << 1;
            ne_d = exp_q - 1'b1;
        end
    end

`ifdef FP_ROUND_NEAREST_EN
    logic [MAN_W+1:0] rsum_d;
    logic             rup;
    assign rup    = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
    assign rsum_d = {1'b0, mant_q[MW-1:3]} + {{(MAN_W+1){1'b0}}, rup};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        x_q     <= x;
                        y_q     <= y;
                        sub_q   <= sub;
                        ovf_q   <= 1'b0;
                        unf_q   <= 1'b0;
                        zero_q  <= 1'b0;
                        state_q <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    sign_q    <= x_ge ? sx : sy;
                    eff_sub_q <= sx ^ sy;
                    exp_q     <= big_e;
                    big_q     <= {big_m, 3'b000};
                    small_q   <= shifted;
                    state_q   <= S_ADD;
                end
                S_ADD: begin
                    mant_q  <= sum_d;
                    state_q <= S_NORM;
                end
                S_NORM: begin
                    mant_q <= nm_d;
                    exp_q  <= ne_d;
                    if (n_exit) begin
                        if (n_ovf) begin
                            result_q <= {sign_q, MAG_MAX};
                            ovf_q    <= 1'b1;
                        end else if (n_zero) begin
                            result_q <= '0;
                            zero_q   <= 1'b1;
                        end else if (n_unf) begin
                            result_q <= {sign_q, {(W-1){1'b0}}};
                            unf_q    <= 1'b1;
                            zero_q   <= 1'b1;
                        end else begin
                            result_q <= {sign_q, ne_d, nm_d[MW-2:3]};
                        end
`ifdef FP_ROUND_NEAREST_EN
                        state_q <= S_ROUND;
`else
                        state_q <= S_DONE;
`endif
                    end
                end
`ifdef FP_ROUND_NEAREST_EN
                S_ROUND: begin
                    // Special results were already finalised in NORM.
                    if (!(ovf_q || unf_q || zero_q)) begin
                        if (rsum_d[MAN_W+1] && exp_q == '1) begin
                            result_q <= {sign_q, MAG_MAX};
                            ovf_q    <= 1'b1;
                        end else if (rsum_d[MAN_W+1]) begin
                            result_q <= {sign_q, exp_q + 1'b1, rsum_d[MAN_W:1]};
                        end else begin
                            result_q <= {sign_q, exp_q, rsum_d[MAN_W-1:0]};
                        end
                    end
                    state_q <= S_DONE;
                end
`endif
                S_DONE: begin
                    if (out_ready) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed self-checking bench for fp_addsub_seq (expectations follow FP_ROUND_NEAREST_EN).
module tb_fp_addsub_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] x, y, result;
    logic        sub, in_valid, in_ready, out_valid, out_ready;
    logic        ovf, unf, zero;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef FP_ROUND_NEAREST_EN
    localparam int RND_EXTRA = 1;
    localparam logic [11:0] RND_5C0_1C0 = 12'h5C1;
`else
    localparam int RND_EXTRA = 0;
    localparam logic [11:0] RND_5C0_1C0 = 12'h5C0;
`endif

    always #5 clk = ~clk;

    fp_addsub_seq #(.EXP_W(4), .MAN_W(7)) dut (
        .clk(clk), .rst(rst), .x(x), .y(y), .sub(sub),
        .in_valid(in_valid), .in_ready(in_ready),
        .result(result), .out_valid(out_valid), .out_ready(out_ready),
        .ovf(ovf), .unf(unf), .zero(zero)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        n_checks++;
        if (got === exp_v) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp_v);
    endtask

    // flags = {ovf, unf, zero}; lat = 2 + NORM cycles
    task automatic run_op(input string tag, input logic [11:0] xv, input logic [11:0] yv,
                          input logic sv, input logic [11:0] er, input logic [2:0] ef,
                          input int lat, input int hold);
        int edges;
        @(negedge clk);
        check({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
        x = xv; y = yv; sub = sv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; x = 12'hABC; y = 12'h123; sub = ~sv;
        edges = 0;
        while (!out_valid && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        check({tag, " latency"}, 32'(edges), 32'(lat + RND_EXTRA));
        check({tag, " result"}, 32'(result), 32'(er));
        check({tag, " flags"}, 32'({ovf, unf, zero}), 32'(ef));
        check({tag, " in_ready busy"}, 32'(in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; x = 12'($urandom);
            @(posedge clk); #1;
            check({tag, " hold valid"}, 32'(out_valid), 32'd1);
            check({tag, " hold result"}, 32'({result, ovf, unf, zero}), 32'({er, ef}));
            check({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, " released"}, 32'({out_valid, in_ready}), 32'b01);
    endtask

    initial begin
        rst = 1'b1; x = '0; y = '0; sub = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset result", 32'(result), 32'd0);
        check("reset flags", 32'({ovf, unf, zero}), 32'd0);
        check("reset handshake", 32'({in_ready, out_valid}), 32'b10);

        run_op("add_carry",  12'h5C0, 12'h540, 1'b0, 12'h610, 3'b000, 3, 0);
        run_op("add_d4",     12'h5C0, 12'h3C0, 1'b0, 12'h5CC, 3'b000, 3, 0);
        run_op("add_d13",    12'h7A8, 12'h101, 1'b0, 12'h7A8, 3'b000, 3, 0);
        run_op("cancel",     12'h5C0, 12'h5C0, 1'b1, 12'h000, 3'b001, 3, 0);
        run_op("overflow",   12'h7FF, 12'h7FF, 1'b0, 12'h7FF, 3'b100, 3, 0);
        run_op("round",      12'h5C0, 12'h1C0, 1'b0, RND_5C0_1C0, 3'b000, 3, 0);
        run_op("norm3",      12'h5C0, 12'h5A0, 1'b1, 12'h480, 3'b000, 5, 0);
        run_op("underflow",  12'h8C0, 12'h8A0, 1'b1, 12'h800, 3'b011, 3, 0);
        run_op("zero_op",    12'h07F, 12'h540, 1'b1, 12'hD40, 3'b000, 3, 0);
        run_op("stall",      12'h5C0, 12'h540, 1'b0, 12'h610, 3'b000, 3, 5);

        // Reset while in NORM: the operation must vanish.
        @(negedge clk);
        x = 12'h5C0; y = 12'h5A0; sub = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check("rst_norm handshake", 32'({in_ready, out_valid}), 32'b10);
        check("rst_norm result", 32'({result, ovf, unf, zero}), 32'd0);
        begin
            int seen = 0;
            for (int i = 0; i < 10; i++) begin
                @(posedge clk); #1;
                if (out_valid) seen++;
            end
            check("rst_norm no out_valid", 32'(seen), 32'd0);
        end

        run_op("after_rst",  12'h5C0, 12'h3C0, 1'b0, 12'h5CC, 3'b000, 3, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
